// File: rtl/packet_fetcher.sv
// Fetches a multi-beat packet from memory, merges the request tag and
// routes the packet to the output channel selected by its opcode.
module packet_fetcher #(
   parameter int DATA_W = 32,
   parameter int WORDS = 6,
   parameter int LAST_W = 15,
   parameter int OP_W = 4,
   parameter int TAG_W = 8,
   parameter int NUM_CH = 3,
   parameter logic [NUM_CH*OP_W-1:0] CH_OPCODES = {4'h3, 4'h2, 4'h1},
   parameter int MAX_OUT = 2,
   localparam int PKT_W = (WORDS-1)*DATA_W + LAST_W
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic [31:0]       OPADDR,
   input  logic              REQ_VALID,
   output logic              REQ_READY,
   input  logic [31:0]       REQ_ADDR,
   input  logic [TAG_W-1:0]  REQ_TAG,
   output logic              MEM_ADDR_VALID,
   input  logic              MEM_ADDR_READY,
   output logic [31:0]       MEM_ADDR,
   input  logic              MEM_RDATA_VALID,
   input  logic [DATA_W-1:0] MEM_RDATA,
   output logic              MEM_RDATA_READY,
   output logic [NUM_CH-1:0] OUT_VALID,
   input  logic [NUM_CH-1:0] OUT_READY,
   output logic [PKT_W-1:0]  OUT_DATA,
   output logic              DROP
);

   localparam int IW = $clog2(WORDS+1);
   localparam int OW = $clog2(MAX_OUT+1);
   localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(WORDS-1);
   localparam logic [IW-1:0] N_BEATS = IW'(WORDS);
   localparam logic [OW-1:0] OUT_MAX = OW'(MAX_OUT);
   localparam logic [31:0] STRIDE = 32'(DATA_W/8);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_DONE = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic              req_ready_q, req_ready_d;
   logic [31:0]       base_q, base_d;
   logic [TAG_W-1:0]  tag_q, tag_d;
   logic [IW-1:0]     issued_q, issued_d;
   logic [IW-1:0]     rcvd_q, rcvd_d;
   logic [OW-1:0]     outst_q, outst_d;
   logic [PKT_W-1:0]  pkt_q, pkt_d;
   logic              out_full_q, out_full_d;
   logic [CW-1:0]     out_ch_q, out_ch_d;
   logic [PKT_W-1:0]  out_data_q, out_data_d;
   logic              drop_q, drop_d;

   logic              addr_hs;
   logic              beat;
   logic              drain;
   logic              match;
   logic [CW-1:0]     sel;
   logic [OP_W-1:0]   opcode;

   assign REQ_READY = req_ready_q;
   assign MEM_RDATA_READY = 1'b1;
   assign MEM_ADDR = base_q + 32'(issued_q) * STRIDE;
   assign MEM_ADDR_VALID = (state_q == S_LOAD) && (issued_q < N_BEATS)
                           && (outst_q < OUT_MAX);
   assign OUT_DATA = out_data_q;
   assign DROP = drop_q;

   assign addr_hs = MEM_ADDR_VALID && MEM_ADDR_READY;
   // Beats with nothing outstanding are stale responses from an abandoned load
   assign beat = MEM_RDATA_VALID && (outst_q != '0);
   assign drain = out_full_q && OUT_READY[out_ch_q];
   assign opcode = pkt_q[PKT_W-1 -: OP_W];

   always_comb begin
      OUT_VALID = '0;
      if (out_full_q) OUT_VALID[out_ch_q] = 1'b1;
   end

   // Descending scan so the lowest matching channel wins
   always_comb begin
      match = 1'b0;
      sel = '0;
      for (int i = NUM_CH-1; i >= 0; i--) begin
         if (opcode == CH_OPCODES[i*OP_W +: OP_W]) begin
            match = 1'b1;
            sel = CW'(i);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      base_d = base_q;
      tag_d = tag_q;
      issued_d = issued_q;
      rcvd_d = rcvd_q;
      outst_d = outst_q;
      pkt_d = pkt_q;
      out_full_d = out_full_q && !drain;
      out_ch_d = out_ch_q;
      out_data_d = out_data_q;
      drop_d = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (REQ_VALID && req_ready_q) begin
               state_d = S_LOAD;
               base_d = OPADDR + REQ_ADDR;
               tag_d = REQ_TAG;
               issued_d = '0;
               rcvd_d = '0;
               outst_d = '0;
            end
         end
         S_LOAD: begin
            if (addr_hs) issued_d = issued_q + 1'b1;
            if (addr_hs && !beat) outst_d = outst_q + 1'b1;
            else if (!addr_hs && beat) outst_d = outst_q - 1'b1;
            if (beat) begin
               rcvd_d = rcvd_q + 1'b1;
               for (int k = 0; k < WORDS-1; k++) begin
                  if (rcvd_q == IW'(k))
                     pkt_d[PKT_W-1-k*DATA_W -: DATA_W] = MEM_RDATA;
               end
               if (rcvd_q == LAST_IDX) begin
                  pkt_d[LAST_W-1:0] = MEM_RDATA[LAST_W-1:0];
                  pkt_d[PKT_W-OP_W-1 -: TAG_W] = tag_q;
                  state_d = S_DONE;
               end
            end
         end
         S_DONE: begin
            if (!match) begin
               drop_d = 1'b1;
               state_d = S_IDLE;
            end else if (!out_full_q || drain) begin
               out_full_d = 1'b1;
               out_ch_d = sel;
               out_data_d = pkt_q;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      req_ready_d = (state_d == S_IDLE);
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= S_IDLE;
         req_ready_q <= 1'b0;
         base_q <= '0;
         tag_q <= '0;
         issued_q <= '0;
         rcvd_q <= '0;
         outst_q <= '0;
         pkt_q <= '0;
         out_full_q <= 1'b0;
         out_ch_q <= '0;
         out_data_q <= '0;
         drop_q <= 1'b0;
      end else begin
         state_q <= state_d;
         req_ready_q <= req_ready_d;
         base_q <= base_d;
         tag_q <= tag_d;
         issued_q <= issued_d;
         rcvd_q <= rcvd_d;
         outst_q <= outst_d;
         pkt_q <= pkt_d;
         out_full_q <= out_full_d;
         out_ch_q <= out_ch_d;
         out_data_q <= out_data_d;
         drop_q <= drop_d;
      end
   end

endmodule
